// File: rtl/boot_pkg.sv
// Shared constants for the instruction-memory boot loader.
// State encoding and frame geometry used by the loader FSM and packer.
package boot_pkg;

    localparam logic [2:0] ST_LEN0 = 3'd0;
    localparam logic [2:0] ST_LEN1 = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian 4-byte to 32-bit word assembler.
// word_valid is combinational on the byte that completes a word.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] sr;

    assign word       = {in_data, sr};
    assign word_valid = in_valid
                     && (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 2'd0;
            sr  <= 24'd0;
        end else if (in_valid) begin
            cnt <= cnt + 2'd1;
            sr  <= {in_data, sr[23:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the CPU instruction memory.
// Holds the CPU in reset until the frame checksum verifies.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

    logic [2:0]  state;
    logic [7:0]  len_lo;
    logic [7:0]  xacc;
    logic [15:0] wcnt;
    logic [15:0] nwords;
    logic [15:0] len;
    logic [15:0] wcnt_nx;
    logic        acc;
    logic        pk_in;
    logic        pk_valid;
    logic [31:0] pk_word;

    assign in_ready = (state == ST_LEN0)
                   || (state == ST_LEN1)
                   || (state == ST_DATA)
                   || (state == ST_CSUM);

    assign acc      = in_valid && in_ready;
    assign len      = {in_data, len_lo};
    assign wcnt_nx  = wcnt + 16'd1;
    assign pk_in    = acc && (state == ST_DATA);

    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERR);
    assign cpu_hold = (state != ST_DONE);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (pk_in),
        .in_data    (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_LEN0;
            len_lo     <= 8'd0;
            xacc       <= 8'd0;
            wcnt       <= 16'd0;
            nwords     <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;

            // the checksum byte itself is never folded in
            if (acc && (state != ST_CSUM))
                xacc <= xacc ^ in_data;

            if (pk_valid) begin
                imem_we    <= 1'b1;
                imem_addr  <= wcnt[ADDR_W-1:0];
                imem_wdata <= pk_word;
                wcnt       <= wcnt_nx;
            end

            if (acc) begin
                unique case (1'b1)
                    state == ST_LEN0: begin
                        len_lo <= in_data;
                        state  <= ST_LEN1;
                    end
                    state == ST_LEN1: begin
                        nwords <= len;
                        if ({1'b0, len} > DEPTH_L)
                            state <= ST_ERR;
                        else if (len == 16'd0)
                            state <= ST_CSUM;
                        else
                            state <= ST_DATA;
                    end
                    state == ST_DATA: begin
                        if (pk_valid && (wcnt_nx == nwords))
                            state <= ST_CSUM;
                    end
                    state == ST_CSUM: begin
                        state <= (in_data == xacc)
                               ? ST_DONE : ST_ERR;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader.
// A frame-level model predicts writes and status every cycle.
module tb_imem_boot_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    imem_boot_loader #(
        .IMEM_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    logic [31:0] mem [0:DEPTH-1];

    // frame model: byte count, length, running xor, phase
    int          macc;
    int          m_n;
    int          m_st;
    logic [7:0]  m_lo;
    logic [7:0]  m_x;
    logic [31:0] m_word;

    logic        acc_pend = 1'b0;
    logic [7:0]  byte_pend = 8'd0;

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h",
                     nm, got, exp);
        end
    endtask

    task automatic model_reset();
        macc   = 0;
        m_n    = 0;
        m_st   = 0;
        m_lo   = 8'd0;
        m_x    = 8'd0;
        m_word = 32'd0;
    endtask

    task automatic model_accept(input logic [7:0] d,
                                output logic e_we,
                                output int e_a,
                                output logic [31:0] e_d);
        int k;
        e_we = 1'b0;
        e_a  = 0;
        e_d  = 32'd0;
        if (m_st != 0) return;
        if (macc == 0) begin
            m_lo = d;
            m_x  = m_x ^ d;
        end else if (macc == 1) begin
            m_n = int'({d, m_lo});
            m_x = m_x ^ d;
            if (m_n > DEPTH) m_st = 2;
        end else if (macc < 2 + 4 * m_n) begin
            k = macc - 2;
            m_word[8*(k%4) +: 8] = d;
            m_x = m_x ^ d;
            if (k % 4 == 3) begin
                e_we = 1'b1;
                e_a  = k / 4;
                e_d  = m_word;
            end
        end else begin
            m_st = (d == m_x) ? 1 : 2;
        end
        macc++;
    endtask

    // sample the handshake just before the rising edge
    always @(negedge clk) begin
        #4;
        if (rst && in_valid && in_ready) begin
            acc_pend  = 1'b1;
            byte_pend = in_data;
        end
    end

    always @(negedge clk) begin
        logic        e_we;
        int          e_a;
        logic [31:0] e_d;
        if (!rst) begin
            model_reset();
            acc_pend = 1'b0;
            chk("rst imem_we", 32'(imem_we), 32'd0);
            chk("rst imem_addr", 32'(imem_addr), 32'd0);
            chk("rst imem_wdata", imem_wdata, 32'd0);
            chk("rst in_ready", 32'(in_ready), 32'd1);
            chk("rst cpu_hold", 32'(cpu_hold), 32'd1);
            chk("rst done", 32'(done), 32'd0);
            chk("rst error", 32'(error), 32'd0);
        end else begin
            e_we = 1'b0;
            e_a  = 0;
            e_d  = 32'd0;
            if (acc_pend) begin
                model_accept(byte_pend, e_we, e_a, e_d);
                acc_pend = 1'b0;
            end
            chk("imem_we", 32'(imem_we), 32'(e_we));
            if (e_we) begin
                chk("imem_addr", 32'(imem_addr), 32'(e_a));
                chk("imem_wdata", imem_wdata, e_d);
            end
            chk("in_ready", 32'(in_ready), 32'(m_st == 0));
            chk("cpu_hold", 32'(cpu_hold), 32'(m_st != 1));
            chk("done", 32'(done), 32'(m_st == 1));
            chk("error", 32'(error), 32'(m_st == 2));
            if (imem_we) begin
                mem[imem_addr] = imem_wdata;
                wr_cnt++;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hdeadbeef;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst    = 1'b0;
        wr_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic send(input logic [7:0] q[$], input int gap);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = q[i];
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        #1;
    endtask

    logic [7:0] sa[$];
    logic [7:0] sb[$];
    logic [7:0] sp[$];

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        model_reset();
        clear_mem();
        sa = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h78, 8'h56, 8'h34, 8'h12, 8'h19};
        sb = sa;
        sb[10] = 8'h18;
        sp = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;

        send(sa, 0);
        settle();
        chk("t1 writes", 32'(wr_cnt), 32'd2);
        chk("t1 mem0", mem[0], 32'h00000013);
        chk("t1 mem1", mem[1], 32'h12345678);
        chk("t1 done", 32'(done), 32'd1);
        chk("t1 cpu_hold", 32'(cpu_hold), 32'd0);
        chk("t1 error", 32'(error), 32'd0);

        do_reset();
        clear_mem();
        send(sa, 3);
        settle();
        chk("t2 writes", 32'(wr_cnt), 32'd2);
        chk("t2 mem0", mem[0], 32'h00000013);
        chk("t2 mem1", mem[1], 32'h12345678);
        chk("t2 done", 32'(done), 32'd1);

        do_reset();
        clear_mem();
        send('{8'h00, 8'h00, 8'h00}, 0);
        settle();
        chk("t3 writes", 32'(wr_cnt), 32'd0);
        chk("t3 done", 32'(done), 32'd1);
        chk("t3 cpu_hold", 32'(cpu_hold), 32'd0);

        do_reset();
        send('{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 0);
        settle();
        chk("t4 writes", 32'(wr_cnt), 32'd0);
        chk("t4 error", 32'(error), 32'd1);
        chk("t4 in_ready", 32'(in_ready), 32'd0);
        chk("t4 cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t4 done", 32'(done), 32'd0);

        do_reset();
        clear_mem();
        send(sb, 0);
        settle();
        chk("t5 writes", 32'(wr_cnt), 32'd2);
        chk("t5 mem1", mem[1], 32'h12345678);
        chk("t5 error", 32'(error), 32'd1);
        chk("t5 done", 32'(done), 32'd0);
        chk("t5 cpu_hold", 32'(cpu_hold), 32'd1);

        do_reset();
        clear_mem();
        send(sp, 0);
        #1;
        chk("t6 partial writes", 32'(wr_cnt), 32'd1);
        do_reset();
        chk("t6 hold in reset", 32'(cpu_hold), 32'd1);
        clear_mem();
        send(sa, 0);
        settle();
        chk("t6 writes", 32'(wr_cnt), 32'd2);
        chk("t6 mem0", mem[0], 32'h00000013);
        chk("t6 mem1", mem[1], 32'h12345678);
        chk("t6 done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
